// File: rtl/ibuffer.sv
// ---------------------------------------------------------------------------
// ibuffer -- instruction buffer between fetch and decode.
//
// Takes one fetch group per cycle (up to INSTR_PER_FETCH lanes with a
// per-lane valid mask). It compacts the valid lanes, in lane order, into a
// circular queue. The DEC_WIDTH oldest entries are presented to decode each
// cycle. A flush empties the queue in one cycle.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   fe_valid_i/fe_ready_o fetch handshake (ready = room for a whole group)
//   fe_data_i             INSTR_PER_FETCH x ILEN instruction words, lane 0 low
//   fe_pc_i               PC of lane 0
//   fe_slot_valid_i       per-lane valid mask (holes allowed)
//   fe_pred_npc_i         INSTR_PER_FETCH x PLEN predicted next PCs
//   de_valid_o            contiguous-prefix lane valid towards decode
//   de_ready_i            decode consumes every valid lane this cycle
//   de_instr_o/de_pc_o/de_pred_npc_o  per-lane decode payload
//   flush_i               discard all contents
//   count_o               number of occupied entries
// ---------------------------------------------------------------------------
package config_pkg;
  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned PLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 4, ILEN: 32, PLEN: 32};
endpackage

module ibuffer #(
  parameter config_pkg::cfg_t Cfg       = config_pkg::EmptyCfg,
  parameter int unsigned      DEPTH     = 16,
  parameter int unsigned      DEC_WIDTH = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           fe_valid_i,
  output logic                                           fe_ready_o,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]        fe_data_i,
  input  logic [Cfg.PLEN-1:0]                            fe_pc_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                 fe_slot_valid_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.PLEN-1:0]        fe_pred_npc_i,
  output logic [DEC_WIDTH-1:0]                           de_valid_o,
  input  logic                                           de_ready_i,
  output logic [DEC_WIDTH*Cfg.ILEN-1:0]                  de_instr_o,
  output logic [DEC_WIDTH*Cfg.PLEN-1:0]                  de_pc_o,
  output logic [DEC_WIDTH*Cfg.PLEN-1:0]                  de_pred_npc_o,
  input  logic                                           flush_i,
  output logic [$clog2(DEPTH+1)-1:0]                     count_o
);

  localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN = Cfg.ILEN;
  localparam int unsigned PLEN = Cfg.PLEN;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH+1);

  // Entry storage; not reset, contents are don't-care while unoccupied.
  logic [ILEN-1:0] instr_q    [DEPTH];
  logic [PLEN-1:0] pc_q       [DEPTH];
  logic [PLEN-1:0] pred_npc_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq_fire;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_n;
  logic [CW-1:0] deq_amt;
  logic [PW-1:0] wr_idx [IPF];

  // Conservative: only the registered count is looked at, so there is no
  // path from de_ready_i into fe_ready_o.
  assign fe_ready_o = (count_q <= CW'(DEPTH - IPF)) && !flush_i;
  assign enq_fire   = fe_valid_i && fe_ready_o;

  // Compaction: each valid lane goes to tail + (number of valid lanes below it).
  always_comb begin
    logic [CW-1:0] run;
    run = '0;
    for (int l = 0; l < int'(IPF); l++) begin
      wr_idx[l] = tail_q + run[PW-1:0];
      run       = run + CW'(fe_slot_valid_i[l]);
    end
    enq_n = enq_fire ? run : '0;
  end

  assign deq_n   = (count_q > CW'(DEC_WIDTH)) ? CW'(DEC_WIDTH) : count_q;
  assign deq_amt = de_ready_i ? deq_n : '0;

  always_comb begin
    head_d  = head_q + deq_amt[PW-1:0];
    tail_d  = tail_q + enq_n[PW-1:0];
    count_d = count_q + enq_n - deq_amt;
    // Flush beats any same-cycle enqueue or dequeue.
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry writes; lanes target distinct indices, so no write conflicts.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < int'(IPF); l++) begin
      if (enq_fire && fe_slot_valid_i[l]) begin
        instr_q[wr_idx[l]]    <= fe_data_i[l*ILEN +: ILEN];
        pc_q[wr_idx[l]]       <= fe_pc_i + PLEN'(l * 4);
        pred_npc_q[wr_idx[l]] <= fe_pred_npc_i[l*PLEN +: PLEN];
      end
    end
  end

  // Decode read muxes: lane i shows head+i (power-of-2 wrap by truncation).
  generate
    for (genvar gi = 0; gi < int'(DEC_WIDTH); gi++) begin : g_dec
      logic [PW-1:0] rd_idx;
      assign rd_idx                            = head_q + PW'(gi);
      assign de_valid_o[gi]                    = count_q > CW'(gi);
      assign de_instr_o[gi*ILEN +: ILEN]       = instr_q[rd_idx];
      assign de_pc_o[gi*PLEN +: PLEN]          = pc_q[rd_idx];
      assign de_pred_npc_o[gi*PLEN +: PLEN]    = pred_npc_q[rd_idx];
    end
  endgenerate

  assign count_o = count_q;

endmodule

// File: tb/tb_ibuffer.sv
// ---------------------------------------------------------------------------
// tb_ibuffer -- self-checking bench for ibuffer (IPF=4, ILEN=32, PLEN=32,
// DEPTH=16, DEC_WIDTH=4). A queue of entries serves as the reference. Every
// cycle, the outputs are compared against that queue. Directed scenarios
// come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_ibuffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fe_valid_i;
  logic         fe_ready_o;
  logic [127:0] fe_data_i;
  logic [31:0]  fe_pc_i;
  logic [3:0]   fe_slot_valid_i;
  logic [127:0] fe_pred_npc_i;
  logic [3:0]   de_valid_o;
  logic         de_ready_i;
  logic [127:0] de_instr_o;
  logic [127:0] de_pc_o;
  logic [127:0] de_pred_npc_o;
  logic         flush_i;
  logic [4:0]   count_o;

  ibuffer #(.DEPTH(16), .DEC_WIDTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fe_valid_i     (fe_valid_i),
    .fe_ready_o     (fe_ready_o),
    .fe_data_i      (fe_data_i),
    .fe_pc_i        (fe_pc_i),
    .fe_slot_valid_i(fe_slot_valid_i),
    .fe_pred_npc_i  (fe_pred_npc_i),
    .de_valid_o     (de_valid_o),
    .de_ready_i     (de_ready_i),
    .de_instr_o     (de_instr_o),
    .de_pc_o        (de_pc_o),
    .de_pred_npc_o  (de_pred_npc_o),
    .flush_i        (flush_i),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t model_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, update the
  // model with what the edge should do, then let the posedge happen.
  task automatic step(input bit fv, input logic [3:0] m, input logic [31:0] pc,
                      input bit fl, input bit dr);
    int   n;
    bit   rdy;
    ent_t e;
    @(negedge clk_i);
    fe_valid_i      = fv;
    fe_slot_valid_i = m;
    fe_pc_i         = pc;
    flush_i         = fl;
    de_ready_i      = dr;
    for (int l = 0; l < 4; l++) begin
      fe_data_i[l*32 +: 32]     = $urandom;
      fe_pred_npc_i[l*32 +: 32] = $urandom;
    end
    #1;
    rdy = ((16 - int'(model_q.size())) >= 4) && !fl;
    n   = (model_q.size() < 4) ? int'(model_q.size()) : 4;
    check_val("count", 64'(count_o), 64'(model_q.size()));
    check_val("fe_ready", 64'(fe_ready_o), 64'(rdy));
    check_val("de_valid", 64'(de_valid_o), 64'((1 << n) - 1));
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("instr%0d", i), 64'(de_instr_o[i*32 +: 32]), 64'(model_q[i].instr));
      check_val($sformatf("pc%0d", i), 64'(de_pc_o[i*32 +: 32]), 64'(model_q[i].pc));
      check_val($sformatf("npc%0d", i), 64'(de_pred_npc_o[i*32 +: 32]), 64'(model_q[i].npc));
    end
    if (fl) begin
      model_q.delete();
    end else begin
      if (dr) repeat (n) void'(model_q.pop_front());
      if (fv && rdy) begin
        for (int l = 0; l < 4; l++) begin
          if (m[l]) begin
            e.instr = fe_data_i[l*32 +: 32];
            e.pc    = pc + 32'(4 * l);
            e.npc   = fe_pred_npc_i[l*32 +: 32];
            model_q.push_back(e);
          end
        end
      end
    end
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_i = 1'b1; fe_valid_i = 0; fe_slot_valid_i = 0; fe_pc_i = 0;
    fe_data_i = 0; fe_pred_npc_i = 0; flush_i = 0; de_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_count", 64'(count_o), 64'd0);
    check_val("rst_valid", 64'(de_valid_o), 64'd0);
    check_val("rst_ready", 64'(fe_ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic pass-through
    step(1, 4'b1111, 32'h8000_0000, 0, 1);
    check_val("pt_valid", 64'(de_valid_o), 64'hF);
    check_val("pt_pc3", 64'(de_pc_o[96 +: 32]), 64'h8000_000C);
    step(0, 4'b0000, 32'h0, 0, 1);
    check_val("pt_drain", 64'(count_o), 64'd0);

    // Compaction
    step(1, 4'b1010, 32'h100, 0, 0);
    check_val("cmp_valid", 64'(de_valid_o), 64'h3);
    check_val("cmp_pc0", 64'(de_pc_o[0 +: 32]), 64'h104);
    check_val("cmp_pc1", 64'(de_pc_o[32 +: 32]), 64'h10C);
    check_val("cmp_count", 64'(count_o), 64'd2);
    step(0, 4'b0000, 32'h0, 0, 1);

    // Wrap-around: flush to zero, then move head/tail to 14
    step(0, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1111, 32'h1000, 0, 1);
    step(1, 4'b1111, 32'h1010, 0, 1);
    step(1, 4'b1111, 32'h1020, 0, 1);
    step(1, 4'b0011, 32'h1030, 0, 1);
    step(0, 4'b0000, 32'h0, 0, 1);
    step(1, 4'b1111, 32'h2000, 0, 0);
    check_val("wrap_valid", 64'(de_valid_o), 64'hF);
    check_val("wrap_pc2", 64'(de_pc_o[64 +: 32]), 64'h2008);
    check_val("wrap_pc3", 64'(de_pc_o[96 +: 32]), 64'h200C);
    step(0, 4'b0000, 32'h0, 0, 1);

    // Full / backpressure
    for (int g = 0; g < 4; g++) step(1, 4'b1111, 32'h3000 + 32'(16 * g), 0, 0);
    check_val("full_count", 64'(count_o), 64'd16);
    check_val("full_ready", 64'(fe_ready_o), 64'd0);
    step(1, 4'b1111, 32'h4000, 0, 0);
    check_val("full_hold", 64'(count_o), 64'd16);
    step(0, 4'b0000, 32'h0, 0, 1);
    check_val("deq_count", 64'(count_o), 64'd12);
    check_val("deq_ready", 64'(fe_ready_o), 64'd1);

    // Flush priority at count 8
    step(0, 4'b0000, 32'h0, 0, 1);
    check_val("pre_flush", 64'(count_o), 64'd8);
    step(1, 4'b1111, 32'h5000, 1, 1);
    check_val("fl_count", 64'(count_o), 64'd0);
    check_val("fl_valid", 64'(de_valid_o), 64'd0);

    // Async reset mid-stream at count 6
    step(1, 4'b1111, 32'h6000, 0, 0);
    step(1, 4'b0011, 32'h6010, 0, 0);
    fe_valid_i = 0;
    #1;
    rst_i = 1'b1;
    #1;
    check_val("ar_count", 64'(count_o), 64'd0);
    check_val("ar_valid", 64'(de_valid_o), 64'd0);
    model_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Randomized traffic with varying decode pressure
    for (int ph = 0; ph < 10; ph++) begin
      int dr_pct;
      dr_pct = $urandom_range(10, 90);
      for (int c = 0; c < 50; c++) begin
        step($urandom_range(0, 99) < 75, 4'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < dr_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
